// File: rtl/vram_bus_arbiter.sv
// Arbitrates the PPU render tile fetcher and the CPU register port onto one VRAM bus.
// Every access is a fixed four-cycle LATCH/HOLD/STROBE/CAPTURE sequence; render has priority with bounded CPU wait.
module vram_bus_arbiter #(
    parameter int MAX_CPU_WAIT = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_renderReq,
    input  logic [13:0] i_renderAddr,
    output logic        o_renderGrant,
    output logic        o_renderDone,
    output logic [7:0]  o_renderData,
    input  logic        i_cpuReq,
    input  logic        i_cpuWrite,
    input  logic [13:0] i_cpuAddr,
    input  logic [7:0]  i_cpuWData,
    output logic        o_cpuGrant,
    output logic        o_cpuDone,
    output logic [7:0]  o_cpuRData,
    output logic [13:0] o_vRamAddressOut,
    output logic        o_addressLatch,
    output logic        o_vRamRead,
    output logic        o_vRamWrite,
    output logic [7:0]  o_vRamDataOut,
    output logic        o_vRamDataOe,
    input  logic [7:0]  i_vRamDataIn
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LATCH   = 3'd1;
    localparam logic [2:0] HOLD    = 3'd2;
    localparam logic [2:0] STROBE  = 3'd3;
    localparam logic [2:0] CAPTURE = 3'd4;

    localparam logic [3:0] MAX_WAIT = 4'(MAX_CPU_WAIT);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [3:0]  r_waitCount;
    logic        r_isCpu;
    logic        r_isWrite;
    logic [13:0] r_addr;
    logic [7:0]  r_wdata;
    logic        r_renderGrant;
    logic        r_cpuGrant;
    logic        r_renderDone;
    logic        r_cpuDone;
    logic [7:0]  r_renderData;
    logic [7:0]  r_cpuRData;

    logic w_arbitrate;
    logic w_cpuWins;
    logic w_renderWins;
    logic w_inStrobe;

    // CPU only overtakes render once it has watched MAX_CPU_WAIT render grants go by
    always_comb begin
        w_arbitrate  = (r_state == IDLE) || (r_state == CAPTURE);
        w_cpuWins    = i_cpuReq && (!i_renderReq || (r_waitCount == MAX_WAIT));
        w_renderWins = i_renderReq && !w_cpuWins;
        w_inStrobe   = (r_state == STROBE) || (r_state == CAPTURE);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = (w_cpuWins || w_renderWins) ? LATCH : IDLE;
            LATCH:   w_state_next = HOLD;
            HOLD:    w_state_next = STROBE;
            STROBE:  w_state_next = CAPTURE;
            CAPTURE: w_state_next = (w_cpuWins || w_renderWins) ? LATCH : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state       <= IDLE;
            r_waitCount   <= 4'd0;
            r_isCpu       <= 1'b0;
            r_isWrite     <= 1'b0;
            r_addr        <= 14'd0;
            r_wdata       <= 8'd0;
            r_renderGrant <= 1'b0;
            r_cpuGrant    <= 1'b0;
            r_renderDone  <= 1'b0;
            r_cpuDone     <= 1'b0;
            r_renderData  <= 8'd0;
            r_cpuRData    <= 8'd0;
        end else begin
            r_state       <= w_state_next;
            r_renderGrant <= w_arbitrate && w_renderWins;
            r_cpuGrant    <= w_arbitrate && w_cpuWins;
            r_renderDone  <= (r_state == CAPTURE) && !r_isCpu;
            r_cpuDone     <= (r_state == CAPTURE) && r_isCpu;

            if (!i_cpuReq)
                r_waitCount <= 4'd0;
            else if (w_arbitrate && w_cpuWins)
                r_waitCount <= 4'd0;
            else if (w_arbitrate && w_renderWins && (r_waitCount != MAX_WAIT))
                r_waitCount <= r_waitCount + 4'd1;

            if (w_arbitrate && w_cpuWins) begin
                r_isCpu   <= 1'b1;
                r_isWrite <= i_cpuWrite;
                r_addr    <= i_cpuAddr;
                r_wdata   <= i_cpuWData;
            end else if (w_arbitrate && w_renderWins) begin
                r_isCpu   <= 1'b0;
                r_isWrite <= 1'b0;
                r_addr    <= i_renderAddr;
            end

            // Read data is taken on the edge that closes CAPTURE
            if ((r_state == CAPTURE) && !r_isWrite) begin
                if (r_isCpu)
                    r_cpuRData <= i_vRamDataIn;
                else
                    r_renderData <= i_vRamDataIn;
            end
        end
    end

    always_comb begin
        o_renderGrant    = r_renderGrant;
        o_cpuGrant       = r_cpuGrant;
        o_renderDone     = r_renderDone;
        o_cpuDone        = r_cpuDone;
        o_renderData     = r_renderData;
        o_cpuRData       = r_cpuRData;
        o_vRamAddressOut = r_addr;
        o_addressLatch   = (r_state == LATCH);
        o_vRamRead       = !(w_inStrobe && !r_isWrite);
        o_vRamWrite      = !(w_inStrobe && r_isWrite);
        o_vRamDataOe     = w_inStrobe && r_isWrite;
        o_vRamDataOut    = r_wdata;
    end

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Directed bench for vram_bus_arbiter: single accesses, contention, wait-counter clear and mid-access reset.
module tb_vram_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        render_req;
    logic [13:0] render_addr;
    logic        render_grant;
    logic        render_done;
    logic [7:0]  render_data;
    logic        cpu_req;
    logic        cpu_write;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_grant;
    logic        cpu_done;
    logic [7:0]  cpu_rdata;
    logic [13:0] vram_addr;
    logic        addr_latch;
    logic        vram_rd_n;
    logic        vram_wr_n;
    logic [7:0]  vram_dout;
    logic        vram_oe;
    logic [7:0]  vram_din;

    int n_checks;
    int n_fails;

    vram_bus_arbiter #(.MAX_CPU_WAIT(4)) dut (
        .i_clock          (clk),
        .i_reset          (rst_n),
        .i_renderReq      (render_req),
        .i_renderAddr     (render_addr),
        .o_renderGrant    (render_grant),
        .o_renderDone     (render_done),
        .o_renderData     (render_data),
        .i_cpuReq         (cpu_req),
        .i_cpuWrite       (cpu_write),
        .i_cpuAddr        (cpu_addr),
        .i_cpuWData       (cpu_wdata),
        .o_cpuGrant       (cpu_grant),
        .o_cpuDone        (cpu_done),
        .o_cpuRData       (cpu_rdata),
        .o_vRamAddressOut (vram_addr),
        .o_addressLatch   (addr_latch),
        .o_vRamRead       (vram_rd_n),
        .o_vRamWrite      (vram_wr_n),
        .o_vRamDataOut    (vram_dout),
        .o_vRamDataOe     (vram_oe),
        .i_vRamDataIn     (vram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grants and dones from the two ports must never overlap
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("grant_exclusive", 32'(render_grant & cpu_grant), 32'd0);
            check_eq("done_exclusive", 32'(render_done & cpu_done), 32'd0);
        end
    end

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        rst_n       = 1'b0;
        render_req  = 1'b0;
        render_addr = 14'd0;
        cpu_req     = 1'b0;
        cpu_write   = 1'b0;
        cpu_addr    = 14'd0;
        cpu_wdata   = 8'd0;
        vram_din    = 8'd0;

        tick();
        tick();
        check_eq("rst_rgrant", 32'(render_grant), 32'd0);
        check_eq("rst_cgrant", 32'(cpu_grant), 32'd0);
        check_eq("rst_rdone", 32'(render_done), 32'd0);
        check_eq("rst_cdone", 32'(cpu_done), 32'd0);
        check_eq("rst_latch", 32'(addr_latch), 32'd0);
        check_eq("rst_rd_n", 32'(vram_rd_n), 32'd1);
        check_eq("rst_wr_n", 32'(vram_wr_n), 32'd1);
        check_eq("rst_oe", 32'(vram_oe), 32'd0);
        check_eq("rst_addr", 32'(vram_addr), 32'd0);
        check_eq("rst_dout", 32'(vram_dout), 32'd0);
        check_eq("rst_rdata", 32'(render_data), 32'd0);
        check_eq("rst_cdata", 32'(cpu_rdata), 32'd0);
        $display("txn reset: done");
        rst_n = 1'b1;
        tick();

        // Single render read of 0x23C5
        render_req  = 1'b1;
        render_addr = 14'h23C5;
        vram_din    = 8'h11;
        tick();
        check_eq("r1_grant", 32'(render_grant), 32'd1);
        check_eq("r1_latch", 32'(addr_latch), 32'd1);
        check_eq("r1_addr", 32'(vram_addr), 32'h23C5);
        check_eq("r1_rd_latch", 32'(vram_rd_n), 32'd1);
        render_req  = 1'b0;
        render_addr = 14'h0000;
        tick();
        check_eq("r1_hold_latch", 32'(addr_latch), 32'd0);
        check_eq("r1_hold_addr", 32'(vram_addr), 32'h23C5);
        check_eq("r1_hold_grant", 32'(render_grant), 32'd0);
        tick();
        check_eq("r1_strobe_rd", 32'(vram_rd_n), 32'd0);
        check_eq("r1_strobe_wr", 32'(vram_wr_n), 32'd1);
        tick();
        check_eq("r1_capture_rd", 32'(vram_rd_n), 32'd0);
        vram_din = 8'hA7;
        tick();
        check_eq("r1_done", 32'(render_done), 32'd1);
        check_eq("r1_data", 32'(render_data), 32'hA7);
        check_eq("r1_idle_rd", 32'(vram_rd_n), 32'd1);
        check_eq("r1_idle_addr", 32'(vram_addr), 32'h23C5);
        vram_din = 8'h00;
        tick();
        check_eq("r1_done_pulse", 32'(render_done), 32'd0);
        check_eq("r1_data_hold", 32'(render_data), 32'hA7);
        $display("txn render read 0x23C5: data 0x%0h", render_data);

        // CPU read of 0x3F01 to load cpuRData
        cpu_req   = 1'b1;
        cpu_write = 1'b0;
        cpu_addr  = 14'h3F01;
        tick();
        check_eq("c1_grant", 32'(cpu_grant), 32'd1);
        check_eq("c1_addr", 32'(vram_addr), 32'h3F01);
        cpu_req = 1'b0;
        tick();
        tick();
        check_eq("c1_strobe_rd", 32'(vram_rd_n), 32'd0);
        tick();
        vram_din = 8'h5A;
        tick();
        check_eq("c1_done", 32'(cpu_done), 32'd1);
        check_eq("c1_rdone", 32'(render_done), 32'd0);
        check_eq("c1_data", 32'(cpu_rdata), 32'h5A);
        check_eq("c1_render_data", 32'(render_data), 32'hA7);
        $display("txn cpu read 0x3F01: data 0x%0h", cpu_rdata);

        // CPU write 0x0F to 0x3F00; inputs change after grant
        cpu_req   = 1'b1;
        cpu_write = 1'b1;
        cpu_addr  = 14'h3F00;
        cpu_wdata = 8'h0F;
        tick();
        check_eq("w1_grant", 32'(cpu_grant), 32'd1);
        check_eq("w1_addr", 32'(vram_addr), 32'h3F00);
        check_eq("w1_latch", 32'(addr_latch), 32'd1);
        cpu_req   = 1'b0;
        cpu_write = 1'b0;
        cpu_wdata = 8'hFF;
        cpu_addr  = 14'h1234;
        tick();
        check_eq("w1_hold_oe", 32'(vram_oe), 32'd0);
        check_eq("w1_hold_wr", 32'(vram_wr_n), 32'd1);
        tick();
        check_eq("w1_strobe_wr", 32'(vram_wr_n), 32'd0);
        check_eq("w1_strobe_rd", 32'(vram_rd_n), 32'd1);
        check_eq("w1_strobe_oe", 32'(vram_oe), 32'd1);
        check_eq("w1_strobe_dout", 32'(vram_dout), 32'h0F);
        tick();
        check_eq("w1_capture_wr", 32'(vram_wr_n), 32'd0);
        check_eq("w1_capture_oe", 32'(vram_oe), 32'd1);
        check_eq("w1_capture_dout", 32'(vram_dout), 32'h0F);
        vram_din = 8'h33;
        tick();
        check_eq("w1_done", 32'(cpu_done), 32'd1);
        check_eq("w1_rdata_kept", 32'(cpu_rdata), 32'h5A);
        check_eq("w1_idle_wr", 32'(vram_wr_n), 32'd1);
        check_eq("w1_idle_oe", 32'(vram_oe), 32'd0);
        $display("txn cpu write 0x3F00 <= 0x0F: cpuRData 0x%0h", cpu_rdata);

        // Contention: four render grants, one CPU grant, render again
        render_req  = 1'b1;
        render_addr = 14'h2000;
        cpu_req     = 1'b1;
        cpu_write   = 1'b0;
        cpu_addr    = 14'h2400;
        for (int k = 1; k <= 24; k++) begin
            tick();
            check_eq($sformatf("cont_rgrant_%0d", k), 32'(render_grant),
                     32'(((k % 4) == 1) && ((k / 4) != 4)));
            check_eq($sformatf("cont_cgrant_%0d", k), 32'(cpu_grant),
                     32'(k == 17));
            check_eq($sformatf("cont_rdone_%0d", k), 32'(render_done),
                     32'(((k % 4) == 1) && (k >= 5) && (k != 21)));
            check_eq($sformatf("cont_cdone_%0d", k), 32'(cpu_done),
                     32'(k == 21));
        end
        render_req = 1'b0;
        cpu_req    = 1'b0;
        tick();
        check_eq("cont_last_rdone", 32'(render_done), 32'd1);
        tick();
        check_eq("cont_idle_grant", 32'(render_grant | cpu_grant), 32'd0);
        $display("txn contention: 4 render grants, 1 cpu grant, render resumed");

        // cpuReq dropped at waitCount=3 clears the counter
        render_req = 1'b1;
        cpu_req    = 1'b1;
        for (int k = 1; k <= 9; k++) tick();
        check_eq("wc_third_rgrant", 32'(render_grant), 32'd1);
        check_eq("wc_at_three", 32'(dut.r_waitCount), 32'd3);
        cpu_req = 1'b0;
        tick();
        check_eq("wc_cleared", 32'(dut.r_waitCount), 32'd0);
        cpu_req = 1'b1;
        for (int k = 11; k <= 29; k++) begin
            tick();
            check_eq($sformatf("wc_cgrant_%0d", k), 32'(cpu_grant), 32'(k == 29));
            check_eq($sformatf("wc_rgrant_%0d", k), 32'(render_grant),
                     32'((k == 13) || (k == 17) || (k == 21) || (k == 25)));
        end
        render_req = 1'b0;
        cpu_req    = 1'b0;
        for (int k = 30; k <= 33; k++) tick();
        check_eq("wc_cpu_done", 32'(cpu_done), 32'd1);
        tick();
        $display("txn wait clear: cpu granted after 4 fresh render grants");

        // Reset during STROBE abandons the access
        render_req  = 1'b1;
        render_addr = 14'h0155;
        vram_din    = 8'h99;
        tick();
        check_eq("rs_grant", 32'(render_grant), 32'd1);
        render_req = 1'b0;
        tick();
        tick();
        check_eq("rs_strobe_rd", 32'(vram_rd_n), 32'd0);
        rst_n = 1'b0;
        tick();
        check_eq("rs_latch", 32'(addr_latch), 32'd0);
        check_eq("rs_rd_n", 32'(vram_rd_n), 32'd1);
        check_eq("rs_wr_n", 32'(vram_wr_n), 32'd1);
        check_eq("rs_rdone", 32'(render_done), 32'd0);
        check_eq("rs_rdata", 32'(render_data), 32'd0);
        check_eq("rs_cdata", 32'(cpu_rdata), 32'd0);
        check_eq("rs_addr", 32'(vram_addr), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("rs_no_done", 32'(render_done), 32'd0);
        check_eq("rs_idle_rd", 32'(vram_rd_n), 32'd1);
        check_eq("rs_rdata_after", 32'(render_data), 32'd0);
        tick();
        check_eq("rs_still_idle", 32'(vram_rd_n & ~addr_latch), 32'd1);
        $display("txn reset during strobe: access abandoned");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vram_bus_arbiter.md
VRAM_BUS_ARBITER -- requirements
Module: vram_bus_arbiter

Interface
REQ-001 Parameter: MAX_CPU_WAIT, default 4, is the number of consecutive render grants the block allows while cpuReq is pending (range 1-15).
REQ-002 clock  in  1  PPU master clock; all state changes on its rising edge.
REQ-003 reset  in  1  Synchronous, active-low reset; it is sampled on the rising edge of clock.
REQ-004 renderReq  in  1  Request from the render tile fetcher; it is held high until renderGrant.
REQ-005 renderAddr  in  14  Read address from the render tile fetcher.
REQ-006 renderGrant  out  1  One-cycle pulse marking the first (LATCH) cycle of a render access.
REQ-007 renderDone  out  1  One-cycle pulse; renderData is valid in the same cycle.
REQ-008 renderData  out  8  Captured read data for the render port; it holds until the next render capture.
REQ-009 cpuReq  in  1  Request from the CPU register port; it is held high until cpuGrant.
REQ-010 cpuWrite  in  1  CPU access type: 1 = write, 0 = read.
REQ-011 cpuAddr  in  14  CPU VRAM address.
REQ-012 cpuWData  in  8  CPU write data.
REQ-013 cpuGrant, cpuDone  out  1 each  CPU-port equivalents of renderGrant and renderDone.
REQ-014 cpuRData  out  8  Captured CPU read data; it holds until the next CPU read capture.
REQ-015 vRamAddressOut  out  14  VRAM address bus.
REQ-016 addressLatch  out  1  Active-high enable for the external address latch.
REQ-017 vRamRead, vRamWrite  out  1 each  Active-low VRAM read and write strobes.
REQ-018 vRamDataOut  out  8  VRAM write data.
REQ-019 vRamDataOe  out  1  Drive enable for vRamDataOut.
REQ-020 vRamDataIn  in  8  VRAM read data.

Function
REQ-021 FSM states: IDLE, LATCH, HOLD, STROBE, CAPTURE; every access is exactly 4 cycles (LATCH, HOLD, STROBE, CAPTURE).
REQ-022 Arbitration is evaluated in IDLE and in CAPTURE.
  - Pending request: the next state is LATCH, so back-to-back accesses occur with no idle cycle.
  - No request: the next state is IDLE.
REQ-023 Winner selection: render wins over CPU unless cpuReq=1 and waitCount==MAX_CPU_WAIT, in which case CPU wins.
REQ-024 waitCount (4-bit):
  - Increments on each render grant given while cpuReq=1.
  - Clears on a CPU grant and whenever cpuReq=0.
  - Saturates at MAX_CPU_WAIT.
REQ-025 On entry to LATCH, the winner's address, type and write data are registered, and the matching grant pulses high for that LATCH cycle only.
REQ-026 LATCH: addressLatch=1, vRamAddressOut=registered address, both strobes high.
REQ-027 HOLD: addressLatch=0; the address is held.
REQ-028 STROBE and CAPTURE on a read: vRamRead=0.
REQ-029 STROBE and CAPTURE on a write: vRamWrite=0, vRamDataOe=1, vRamDataOut=registered data.
REQ-030 Read data capture: vRamDataIn is sampled on the rising edge that ends CAPTURE, into renderData or cpuRData.
REQ-031 Done pulse: the matching done signal is high for exactly the cycle after CAPTURE, for reads and writes alike.
REQ-032 A CPU write does not modify cpuRData.
REQ-033 Latency: a request seen in IDLE gives grant at +1 cycle and done at +5 cycles; continuous requests give one access per 4 cycles.
REQ-034 Outside LATCH through CAPTURE:
  - addressLatch=0, vRamRead=1, vRamWrite=1, vRamDataOe=0.
  - vRamAddressOut holds its last value.
REQ-035 renderGrant and cpuGrant are never high in the same cycle; likewise renderDone and cpuDone.
REQ-036 Request changes after grant, or during an access, do not affect the access in flight.

Reset
REQ-037 While reset=0 at a clock edge:
  - The state becomes IDLE and waitCount becomes 0.
  - All grant and done pulses are 0.
  - addressLatch=0, vRamRead=1, vRamWrite=1, vRamDataOe=0.
  - vRamAddressOut=0, vRamDataOut=0, renderData=0, cpuRData=0.
REQ-038 A reset during an access abandons it: no done pulse is issued and no data register updates.

Verification
REQ-039 Single render read: renderReq=1, renderAddr=0x23C5, vRamDataIn=0xA7 in CAPTURE -> renderGrant at +1, addressLatch=1 with address 0x23C5 at +1, vRamRead=0 at +3 and +4, renderDone=1 and renderData=0xA7 at +5.
REQ-040 CPU write: cpuReq=1, cpuWrite=1, cpuAddr=0x3F00, cpuWData=0x0F -> vRamWrite=0, vRamDataOe=1 and vRamDataOut=0x0F at +3 and +4; cpuDone at +5; cpuRData unchanged.
REQ-041 Contention (MAX_CPU_WAIT=4): renderReq and cpuReq held high continuously -> 4 render grants, then 1 CPU grant, then render resumes; grants spaced exactly 4 cycles apart.
REQ-042 Simultaneous first request with waitCount=0 -> render granted first; cpuGrant never coincides with renderGrant.
REQ-043 Reset asserted during STROBE -> next cycle is IDLE with strobes high and addressLatch=0; no done pulse; data registers are 0.
REQ-044 cpuReq dropped while waitCount=3 -> waitCount reads 0; a later cpuReq again waits MAX_CPU_WAIT render grants.
